// File: rtl/pixel_renderer.sv
// ============================================================================
// Module   : pixel_renderer
// Summary  : RGB332 pixel source for the VGA path. Object positions and game
//            state are latched into shadow registers once per frame.
//            Optional on-screen health bar enabled by defining HEALTH_BAR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pixel_renderer #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int SPRITE_W     = 32,
    parameter int PROJ_SIZE    = 8,
    parameter int PLAYER_Y     = 440,
    parameter int BLINK_FRAMES = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pix_en,
    input  logic [9:0]  next_x,
    input  logic [9:0]  next_y,
    input  logic [1:0]  state,
    input  logic [9:0]  user_x,
    input  logic [29:0] en_x,
    input  logic [29:0] en_y,
    input  logic [2:0]  en_alive,
    input  logic [9:0]  proj_x,
    input  logic [9:0]  proj_y,
    input  logic        proj_active,
    input  logic [3:0]  health,
    output logic [7:0]  color_out,
    output logic        frame_start
);

    localparam logic [1:0]  c_ST_UPDATE = 2'd1;
    localparam logic [1:0]  c_ST_END    = 2'd2;
    localparam logic [9:0]  c_H_ACTIVE  = 10'(H_ACTIVE);
    localparam logic [9:0]  c_V_ACTIVE  = 10'(V_ACTIVE);
    localparam logic [9:0]  c_PLAYER_Y  = 10'(PLAYER_Y);
    localparam logic [10:0] c_SPR_M1    = 11'(SPRITE_W - 1);
    localparam logic [10:0] c_PROJ_M1   = 11'(PROJ_SIZE - 1);
    localparam logic [5:0]  c_BLINK_MAX = 6'(BLINK_FRAMES - 1);

    logic [1:0]  r_state;
    logic [9:0]  r_user_x;
    logic [29:0] r_en_x;
    logic [29:0] r_en_y;
    logic [2:0]  r_en_alive;
    logic [9:0]  r_proj_x;
    logic [9:0]  r_proj_y;
    logic        r_proj_active;
    logic [5:0]  r_frame_cnt;
    logic        r_blink;

    logic        w_boundary;
    logic        w_active;
    logic        w_proj_hit;
    logic        w_player_hit;
    logic [2:0]  w_en_hit;
    logic        w_title_box;
    logic        w_health_hit;
    logic [7:0]  w_color;

    // Range check carried at 11 bits so obj+size near 1023 does not wrap.
    function automatic logic f_hit(input logic [9:0] px, input logic [9:0] py,
                                   input logic [9:0] ox, input logic [9:0] oy,
                                   input logic [10:0] sm1);
        return ({1'b0, px} >= {1'b0, ox}) && ({1'b0, px} <= ({1'b0, ox} + sm1)) &&
               ({1'b0, py} >= {1'b0, oy}) && ({1'b0, py} <= ({1'b0, oy} + sm1));
    endfunction

    assign w_boundary   = pix_en && (next_x == 10'd0) && (next_y == c_V_ACTIVE);
    assign w_active     = (next_x < c_H_ACTIVE) && (next_y < c_V_ACTIVE);
    assign w_proj_hit   = r_proj_active &&
                          f_hit(next_x, next_y, r_proj_x, r_proj_y, c_PROJ_M1);
    assign w_player_hit = f_hit(next_x, next_y, r_user_x, c_PLAYER_Y, c_SPR_M1);
    assign w_title_box  = (next_y >= 10'd200) && (next_y <= 10'd279) &&
                          (next_x >= 10'd160) && (next_x <= 10'd479);

    generate
        for (genvar i = 0; i < 3; i++) begin : g_enemy
            assign w_en_hit[i] = r_en_alive[i] &&
                                 f_hit(next_x, next_y, r_en_x[10*i +: 10],
                                       r_en_y[10*i +: 10], c_SPR_M1);
        end
    endgenerate

`ifdef HEALTH_BAR_EN
    logic [3:0] r_health;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_health <= 4'd0;
        end else if (w_boundary) begin
            r_health <= health;
        end
    end

    // 16 pixels per health point starting at column 8.
    assign w_health_hit = (next_y >= 10'd8) && (next_y <= 10'd15) &&
                          (next_x >= 10'd8) &&
                          ({1'b0, next_x} < (11'd8 + {3'b000, r_health, 4'b0000}));
`else
    logic w_unused_health;
    assign w_unused_health = ^health;
    assign w_health_hit    = 1'b0;
`endif

    always_comb begin
        w_color = 8'h00;
        if (w_active) begin
            case (r_state)
                c_ST_UPDATE: begin
                    if (w_proj_hit)          w_color = 8'hFF;
                    else if (w_player_hit)   w_color = 8'h1C;
                    else if (|w_en_hit)      w_color = 8'hE0;
                    else if (w_health_hit)   w_color = 8'h1F;
                    else                     w_color = 8'h02;
                end
                c_ST_END: begin
                    if (r_blink)             w_color = 8'hE0;
                end
                default: begin
                    if (r_blink && w_title_box) w_color = 8'hFC;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= 2'd0;
            r_user_x      <= 10'd0;
            r_en_x        <= 30'd0;
            r_en_y        <= 30'd0;
            r_en_alive    <= 3'd0;
            r_proj_x      <= 10'd0;
            r_proj_y      <= 10'd0;
            r_proj_active <= 1'b0;
            r_frame_cnt   <= 6'd0;
            r_blink       <= 1'b0;
            color_out     <= 8'h00;
            frame_start   <= 1'b0;
        end else begin
            frame_start <= w_boundary;
            if (pix_en) begin
                color_out <= w_color;
            end
            if (w_boundary) begin
                r_state       <= state;
                r_user_x      <= user_x;
                r_en_x        <= en_x;
                r_en_y        <= en_y;
                r_en_alive    <= en_alive;
                r_proj_x      <= proj_x;
                r_proj_y      <= proj_y;
                r_proj_active <= proj_active;
                if (r_frame_cnt == c_BLINK_MAX) begin
                    r_frame_cnt <= 6'd0;
                    r_blink     <= ~r_blink;
                end else begin
                    r_frame_cnt <= r_frame_cnt + 6'd1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pixel_renderer.sv
// ============================================================================
// Module   : tb_pixel_renderer
// Summary  : Directed vector bench for pixel_renderer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pixel_renderer;

    logic        clk = 1'b0;
    logic        rst;
    logic        pix_en;
    logic [9:0]  next_x;
    logic [9:0]  next_y;
    logic [1:0]  state;
    logic [9:0]  user_x;
    logic [29:0] en_x;
    logic [29:0] en_y;
    logic [2:0]  en_alive;
    logic [9:0]  proj_x;
    logic [9:0]  proj_y;
    logic        proj_active;
    logic [3:0]  health;
    logic [7:0]  color_out;
    logic        frame_start;

    int n_checks = 0;
    int n_fails  = 0;

`ifdef HEALTH_BAR_EN
    localparam logic [7:0] c_HB = 8'h1F;
`else
    localparam logic [7:0] c_HB = 8'h02;
`endif

    localparam logic [29:0] c_EX = {10'd50, 10'd600, 10'd50};
    localparam logic [29:0] c_EY = {10'd50, 10'd50, 10'd50};

    pixel_renderer dut (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .next_x      (next_x),
        .next_y      (next_y),
        .state       (state),
        .user_x      (user_x),
        .en_x        (en_x),
        .en_y        (en_y),
        .en_alive    (en_alive),
        .proj_x      (proj_x),
        .proj_y      (proj_y),
        .proj_active (proj_active),
        .health      (health),
        .color_out   (color_out),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    typedef struct {
        bit          bnd;
        logic [1:0]  st;
        logic [9:0]  ux;
        logic [29:0] ex;
        logic [29:0] ey;
        logic [2:0]  ea;
        logic [9:0]  px;
        logic [9:0]  py;
        logic        pa;
        logic [3:0]  hp;
        logic [9:0]  rx;
        logic [9:0]  ry;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[20];

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", nm, act, exp);
        end
    endtask

    task automatic request(input logic [9:0] x, input logic [9:0] y);
        @(negedge clk);
        next_x = x;
        next_y = y;
        pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    task automatic boundary();
        request(10'd0, 10'd480);
        chk("frame_start pulse", {7'd0, frame_start}, 8'h01);
        @(negedge clk);
        chk("frame_start clear", {7'd0, frame_start}, 8'h00);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; pix_en = 1'b0; next_x = '0; next_y = '0; state = '0;
        user_x = '0; en_x = '0; en_y = '0; en_alive = '0; proj_x = '0;
        proj_y = '0; proj_active = 1'b0; health = '0;

        //          bnd st  ux      ex    ey    ea      px      py      pa  hp     rx       ry       exp
        vecs[0]  = '{1, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd0, 10'd100, 10'd100, 8'h02};
        vecs[1]  = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd0, 10'd310, 10'd450, 8'h1C};
        vecs[2]  = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd0, 10'd340, 10'd450, 8'h02};
        vecs[3]  = '{0, 1, 10'd0,   0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd0, 10'd310, 10'd450, 8'h1C};
        vecs[4]  = '{1, 1, 10'd0,   0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd0, 10'd310, 10'd450, 8'h02};
        vecs[5]  = '{1, 1, 10'd300, 0,    0,    3'b000, 10'd305,10'd445,1, 4'd0, 10'd306, 10'd446, 8'hFF};
        vecs[6]  = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd305,10'd445,0, 4'd0, 10'd306, 10'd446, 8'hFF};
        vecs[7]  = '{1, 1, 10'd300, 0,    0,    3'b000, 10'd305,10'd445,0, 4'd0, 10'd306, 10'd446, 8'h1C};
        vecs[8]  = '{1, 1, 10'd300, c_EX, c_EY, 3'b101, 10'd305,10'd445,0, 4'd0, 10'd60,  10'd60,  8'hE0};
        vecs[9]  = '{1, 1, 10'd300, c_EX, c_EY, 3'b101, 10'd55, 10'd55, 1, 4'd0, 10'd56,  10'd56,  8'hFF};
        vecs[10] = '{1, 1, 10'd300, c_EX, c_EY, 3'b000, 10'd55, 10'd55, 0, 4'd0, 10'd60,  10'd60,  8'h02};
        vecs[11] = '{1, 1, 10'd300, c_EX, c_EY, 3'b100, 10'd55, 10'd55, 0, 4'd0, 10'd81,  10'd81,  8'hE0};
        vecs[12] = '{0, 1, 10'd300, c_EX, c_EY, 3'b100, 10'd55, 10'd55, 0, 4'd0, 10'd82,  10'd82,  8'h02};
        vecs[13] = '{1, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd55,  10'd10,  c_HB};
        vecs[14] = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd56,  10'd10,  8'h02};
        vecs[15] = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd8,   10'd15,  c_HB};
        vecs[16] = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd7,   10'd15,  8'h02};
        vecs[17] = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd640, 10'd0,   8'h00};
        vecs[18] = '{0, 1, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd639, 10'd479, 8'h02};
        vecs[19] = '{1, 3, 10'd300, 0,    0,    3'b000, 10'd0,  10'd0,  0, 4'd3, 10'd300, 10'd240, 8'h00};

        do_reset();
        chk("reset color", color_out, 8'h00);
        request(10'd100, 10'd100);
        chk("post-reset color", color_out, 8'h00);
        chk("post-reset frame_start", {7'd0, frame_start}, 8'h00);

        for (int i = 0; i < 20; i++) begin
            state = vecs[i].st; user_x = vecs[i].ux; en_x = vecs[i].ex;
            en_y = vecs[i].ey; en_alive = vecs[i].ea; proj_x = vecs[i].px;
            proj_y = vecs[i].py; proj_active = vecs[i].pa; health = vecs[i].hp;
            if (vecs[i].bnd) boundary();
            request(vecs[i].rx, vecs[i].ry);
            chk($sformatf("vec%0d (%0d,%0d)", i, vecs[i].rx, vecs[i].ry),
                color_out, vecs[i].exp);
        end

        // END-screen blink: toggles on the 30th boundary after reset
        do_reset();
        state = 2'd2;
        for (int b = 1; b <= 30; b++) begin
            boundary();
            request(10'd0, 10'd0);
            chk($sformatf("end blink b%0d", b), color_out, (b == 30) ? 8'hE0 : 8'h00);
        end
        request(10'd640, 10'd0);
        chk("end outside", color_out, 8'h00);

        // HOME title box while blink is high
        state = 2'd0;
        boundary();
        request(10'd200, 10'd250);
        chk("home box in", color_out, 8'hFC);
        request(10'd159, 10'd250);
        chk("home box left", color_out, 8'h00);
        request(10'd479, 10'd279);
        chk("home box corner", color_out, 8'hFC);
        request(10'd480, 10'd279);
        chk("home box right", color_out, 8'h00);

        // Asynchronous reset clears colour without a clock edge
        #3 rst = 1'b0;
        #1 chk("async reset color", color_out, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        state = 2'd2;
        request(10'd0, 10'd0);
        chk("post mid-reset home", color_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
